layer_compositor: RTL and testbench
===================================

LAYER_COMPOSITOR -- requirements
Module: layer_compositor

Interface
REQ-001 Parameter N_LAYERS, default 4: number of sprite layers; layer N_LAYERS-1 is drawn topmost.
REQ-002 Parameter COORD_W, default 10: width of screen and local coordinates.
REQ-003 Parameter ROM_LAT, default 1: read latency of the external image ROMs, in cycles, range 1..4.
REQ-004 Parameter MASK_THRESH, default 5: a mask nibble strictly greater than this value marks the pixel opaque.
REQ-005 Parameter FADE_FRAMES, default 4: number of frame starts per fade step.
REQ-006 clk  in  1  system clock; all state updates on its rising edge.
REQ-007 rst_n  in  1  reset, asynchronous and active-low.
REQ-008 i_valid  in  1  pixel request qualifier.
REQ-009 i_x_read, i_y_read  in  COORD_W each  screen pixel being requested.
REQ-010 i_frame_start  in  1  one-cycle pulse per frame.
REQ-011 i_layer_en  in  N_LAYERS  per-layer display enable.
REQ-012 i_layer_x, i_layer_y, i_layer_w, i_layer_h  in  N_LAYERS*COORD_W each  layer origin and size; layer k occupies bits [k*COORD_W +: COORD_W].
REQ-013 i_bg_color  in  12  background RGB444 colour.
REQ-014 i_fade_req  in  1  level input: 1 requests fade-to-black, 0 requests fade-back.
REQ-015 o_rd_en  out  N_LAYERS  per-layer ROM enable.
REQ-016 o_addr_x, o_addr_y  out  N_LAYERS*COORD_W each  per-layer local ROM coordinates.
REQ-017 i_layer_rgb  in  N_LAYERS*12  ROM colour data, returned ROM_LAT cycles after o_rd_en.
REQ-018 i_layer_mask  in  N_LAYERS*4  ROM mask data, with the same timing as i_layer_rgb.
REQ-019 o_rgb  out  12  composited {r,g,b} pixel.
REQ-020 o_valid  out  1  qualifies o_rgb.
REQ-021 o_fade_level  out  4  current fade level.
REQ-022 o_fade_busy  out  1  high while in FADE_OUT or FADE_IN.

Function
REQ-023 Stage A: per layer, compute local coordinates lx = i_x_read - x and ly = i_y_read - y, both modulo 2^COORD_W.
REQ-024 Stage A: hit_k = i_valid & en_k & (lx < w_k) & (ly < h_k); the unsigned compare rejects pixels left of or above the origin through wrap-around.
REQ-025 Stage A registers o_addr_*, o_rd_en <= hit, and a valid bit, 1 cycle after the request.
REQ-026 Hit and valid bits travel down a ROM_LAT-deep shift register aligned to the ROM data.
REQ-027 Stage C: choose the highest-index layer k with aligned hit_k and mask_k > MASK_THRESH; otherwise use i_bg_color.
REQ-028 Fade: each 4-bit channel is reduced by a saturating subtract of o_fade_level (clamp at 0).
REQ-029 o_rgb and o_valid are registered; total latency from i_valid to o_valid is exactly ROM_LAT+2 cycles.
REQ-030 A back-to-back request stream is accepted every cycle with no bubbles.
REQ-031 Fade FSM states IDLE (level 0), FADE_OUT, DARK (level 15), FADE_IN; it evaluates only on cycles where i_frame_start=1.
REQ-032 Fade FSM transitions:
- IDLE -> FADE_OUT when i_fade_req=1.
- FADE_OUT: frame counter runs 0..FADE_FRAMES-1; at wrap, level increments; at level 15 -> DARK; if i_fade_req=0 -> FADE_IN with level kept.
- DARK -> FADE_IN when i_fade_req=0.
- FADE_IN mirrors FADE_OUT with decrement; at level 0 -> IDLE; if i_fade_req=1 -> FADE_OUT.
REQ-033 The frame counter clears on every state change.
REQ-034 An o_fade_level change takes effect on pixels leaving stage C from the cycle after the frame_start edge.
REQ-035 Simultaneous i_frame_start and i_valid: the pixel is processed normally.
REQ-036 Layers of width 0 or height 0 never hit.
REQ-037 Equal-position overlapping opaque layers resolve by index only.

Reset
REQ-038 Asserting rst_n=0 clears immediately: o_rgb=0, o_valid=0, o_rd_en=0, o_addr_*=0, all pipeline valid and hit bits 0, FSM=IDLE, level=0, frame counter=0, o_fade_busy=0.
REQ-039 Reset mid-stream discards in-flight pixels; the first o_valid after release occurs ROM_LAT+2 cycles after the first valid request.

Verification
REQ-040 Layer0 at (100,50), size 50x100, mask F, rgb 0F0; request (100,50) -> o_addr=(0,0), o_rgb=0F0 after ROM_LAT+2 cycles; request (99,50) -> bg.
REQ-041 Layers 0 and 2 both cover the pixel with rgb 00F and F00, masks 9 and 9 -> F00; set layer2 mask to 5 -> 00F.
REQ-042 Fade: with FADE_FRAMES=4, hold i_fade_req=1 -> level 1 after the 4th frame start, DARK after 60 frame starts; bg FFF reads 000 in DARK.
REQ-043 Drop i_fade_req at level 7 -> FADE_IN, level 6 four frames later, IDLE at level 0; o_fade_busy tracks the FADE states.
REQ-044 A continuous 640-pixel stream yields 640 consecutive o_valid cycles with correct per-pixel order at ROM_LAT=1 and 3.
REQ-045 Pulse rst_n low mid-stream during FADE_OUT -> outputs 0 within the same cycle, FSM=IDLE, no stale o_valid after release.

Source files
------------

// File: rtl/layer_compositor.sv
// Sprite layer compositor: per-layer hit test, ROM-latency-aligned priority
// select over a background colour, and a frame-stepped fade-to-black.
module layer_compositor #(
  parameter int unsigned N_LAYERS    = 4,
  parameter int unsigned COORD_W     = 10,
  parameter int unsigned ROM_LAT     = 1,
  parameter int unsigned MASK_THRESH = 5,
  parameter int unsigned FADE_FRAMES = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_valid,
  input  logic [COORD_W-1:0]            i_x_read,
  input  logic [COORD_W-1:0]            i_y_read,
  input  logic                          i_frame_start,
  input  logic [N_LAYERS-1:0]           i_layer_en,
  input  logic [N_LAYERS*COORD_W-1:0]   i_layer_x,
  input  logic [N_LAYERS*COORD_W-1:0]   i_layer_y,
  input  logic [N_LAYERS*COORD_W-1:0]   i_layer_w,
  input  logic [N_LAYERS*COORD_W-1:0]   i_layer_h,
  input  logic [11:0]                   i_bg_color,
  input  logic                          i_fade_req,
  output logic [N_LAYERS-1:0]           o_rd_en,
  output logic [N_LAYERS*COORD_W-1:0]   o_addr_x,
  output logic [N_LAYERS*COORD_W-1:0]   o_addr_y,
  input  logic [N_LAYERS*12-1:0]        i_layer_rgb,
  input  logic [N_LAYERS*4-1:0]         i_layer_mask,
  output logic [11:0]                   o_rgb,
  output logic                          o_valid,
  output logic [3:0]                    o_fade_level,
  output logic                          o_fade_busy
);

  localparam int unsigned SW    = N_LAYERS + 1;
  localparam int unsigned SRW   = ROM_LAT * SW;
  localparam int unsigned CNT_W = (FADE_FRAMES > 1) ? $clog2(FADE_FRAMES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_FADE_OUT, S_DARK, S_FADE_IN} fade_state_e;

  logic [N_LAYERS*COORD_W-1:0] addr_x_d, addr_y_d, addr_x_q, addr_y_q;
  logic [N_LAYERS-1:0]         hit_d, rd_en_q;
  logic                        vld_a_q;
  logic [SRW-1:0]              align_q;
  logic [N_LAYERS-1:0]         hit_al;
  logic                        vld_al;
  logic [11:0]                 sel_rgb, fade_rgb, rgb_q;
  logic                        valid_q;
  fade_state_e                 state_q, state_d;
  logic [3:0]                  level_q, level_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        busy_q, busy_d;

  // Stage A: local coordinates wrap, so one unsigned compare covers both bounds
  always_comb begin
    addr_x_d = '0;
    addr_y_d = '0;
    hit_d    = '0;
    for (int k = 0; k < int'(N_LAYERS); k++) begin
      addr_x_d[k*COORD_W +: COORD_W] = i_x_read - i_layer_x[k*COORD_W +: COORD_W];
      addr_y_d[k*COORD_W +: COORD_W] = i_y_read - i_layer_y[k*COORD_W +: COORD_W];
      hit_d[k] = i_valid & i_layer_en[k]
               & (addr_x_d[k*COORD_W +: COORD_W] < i_layer_w[k*COORD_W +: COORD_W])
               & (addr_y_d[k*COORD_W +: COORD_W] < i_layer_h[k*COORD_W +: COORD_W]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_x_q <= '0;
      addr_y_q <= '0;
      rd_en_q  <= '0;
      vld_a_q  <= 1'b0;
    end else begin
      addr_x_q <= addr_x_d;
      addr_y_q <= addr_y_d;
      rd_en_q  <= hit_d;
      vld_a_q  <= i_valid;
    end
  end

  // Hit/valid delay line; newest word enters at the bottom, oldest is on top
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) align_q <= '0;
    else        align_q <= SRW'({align_q, vld_a_q, rd_en_q});
  end

  assign {vld_al, hit_al} = align_q[SRW-1 -: SW];

  // Stage C: last qualifying layer in ascending order is the topmost one
  always_comb begin
    sel_rgb  = i_bg_color;
    fade_rgb = '0;
    for (int k = 0; k < int'(N_LAYERS); k++) begin
      if (hit_al[k] && (i_layer_mask[k*4 +: 4] > 4'(MASK_THRESH))) begin
        sel_rgb = i_layer_rgb[k*12 +: 12];
      end
    end
    for (int c = 0; c < 3; c++) begin
      fade_rgb[c*4 +: 4] = (sel_rgb[c*4 +: 4] > level_q) ? (sel_rgb[c*4 +: 4] - level_q) : 4'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= vld_al;
      if (vld_al) rgb_q <= fade_rgb;
    end
  end

  // Fade FSM: only advances on frame-start cycles
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    if (i_frame_start) begin
      case (state_q)
        S_IDLE: if (i_fade_req) state_d = S_FADE_OUT;
        S_FADE_OUT: begin
          if (!i_fade_req) begin
            state_d = S_FADE_IN;
          end else if (cnt_q == CNT_W'(FADE_FRAMES - 1)) begin
            cnt_d   = '0;
            level_d = level_q + 4'd1;
            if (level_q == 4'd14) state_d = S_DARK;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_DARK: if (!i_fade_req) state_d = S_FADE_IN;
        S_FADE_IN: begin
          if (i_fade_req) begin
            state_d = S_FADE_OUT;
          end else if (level_q == 4'd0) begin
            state_d = S_IDLE;
          end else if (cnt_q == CNT_W'(FADE_FRAMES - 1)) begin
            cnt_d   = '0;
            level_d = level_q - 4'd1;
            if (level_q == 4'd1) state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    if (state_d != state_q) cnt_d = '0;
    busy_d = (state_d == S_FADE_OUT) || (state_d == S_FADE_IN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      level_q <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign o_rd_en      = rd_en_q;
  assign o_addr_x     = addr_x_q;
  assign o_addr_y     = addr_y_q;
  assign o_rgb        = rgb_q;
  assign o_valid      = valid_q;
  assign o_fade_level = level_q;
  assign o_fade_busy  = busy_q;

endmodule

// File: tb/tb_layer_compositor.sv
// Bench for layer_compositor: two instances (ROM latency 1 and 3) share stimulus
// and are checked against a per-pixel reference model and a vector table.
module tb_layer_compositor;

  localparam int unsigned N  = 4;
  localparam int unsigned CW = 10;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          valid, frame_start, fade_req;
  logic [CW-1:0] x_rd, y_rd;
  logic [N-1:0]  en;
  logic [11:0]   bg;
  logic [N*CW-1:0] lx_bus, ly_bus, lw_bus, lh_bus;
  int lay_x [N], lay_y [N], lay_w [N], lay_h [N];
  logic [11:0] fix_rgb [N];
  logic [3:0]  fix_mask [N];
  logic        pat_en, chk_en;

  logic [N-1:0] rd1, rd3;
  logic [N*CW-1:0] ax1, ay1, ax3, ay3;
  logic [11:0] rgb1, rgb3;
  logic vld1, vld3, busy1, busy3;
  logic [3:0] lvl1, lvl3;
  logic [N*16-1:0] pipe1 [1];
  logic [N*16-1:0] pipe3 [3];

  int cyc = 0;
  int n_cmp = 0, n_bad = 0;

  typedef struct { logic [11:0] rgb; int due; } exp_t;
  exp_t q1[$], q3[$];

  typedef struct {
    int px, py;
    logic [N-1:0] en;
    logic [11:0] rgb0; logic [3:0] m0;
    logic [11:0] rgb2; logic [3:0] m2;
    logic [11:0] bg;
    logic [11:0] exp_rgb;
    logic [N-1:0] exp_rd;
    logic [CW-1:0] exp_ax0, exp_ay0;
  } vec_t;
  vec_t tbl [15];

  always_comb begin
    lx_bus = '0; ly_bus = '0; lw_bus = '0; lh_bus = '0;
    for (int k = 0; k < int'(N); k++) begin
      lx_bus[k*CW +: CW] = CW'(lay_x[k]);
      ly_bus[k*CW +: CW] = CW'(lay_y[k]);
      lw_bus[k*CW +: CW] = CW'(lay_w[k]);
      lh_bus[k*CW +: CW] = CW'(lay_h[k]);
    end
  end

  layer_compositor #(.N_LAYERS(N), .COORD_W(CW), .ROM_LAT(1), .MASK_THRESH(5), .FADE_FRAMES(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .i_valid(valid), .i_x_read(x_rd), .i_y_read(y_rd),
    .i_frame_start(frame_start), .i_layer_en(en), .i_layer_x(lx_bus), .i_layer_y(ly_bus),
    .i_layer_w(lw_bus), .i_layer_h(lh_bus), .i_bg_color(bg), .i_fade_req(fade_req),
    .o_rd_en(rd1), .o_addr_x(ax1), .o_addr_y(ay1),
    .i_layer_rgb(pipe1[0][N*12-1:0]), .i_layer_mask(pipe1[0][N*16-1:N*12]),
    .o_rgb(rgb1), .o_valid(vld1), .o_fade_level(lvl1), .o_fade_busy(busy1));

  layer_compositor #(.N_LAYERS(N), .COORD_W(CW), .ROM_LAT(3), .MASK_THRESH(5), .FADE_FRAMES(4)) dut3 (
    .clk(clk), .rst_n(rst_n), .i_valid(valid), .i_x_read(x_rd), .i_y_read(y_rd),
    .i_frame_start(frame_start), .i_layer_en(en), .i_layer_x(lx_bus), .i_layer_y(ly_bus),
    .i_layer_w(lw_bus), .i_layer_h(lh_bus), .i_bg_color(bg), .i_fade_req(fade_req),
    .o_rd_en(rd3), .o_addr_x(ax3), .o_addr_y(ay3),
    .i_layer_rgb(pipe3[2][N*12-1:0]), .i_layer_mask(pipe3[2][N*16-1:N*12]),
    .o_rgb(rgb3), .o_valid(vld3), .o_fade_level(lvl3), .o_fade_busy(busy3));

  // ROM image: {mask, rgb} for layer k at local (ax, ay)
  function automatic logic [15:0] rom_word(input int k, input logic [CW-1:0] ax, input logic [CW-1:0] ay);
    if (pat_en) return {4'((int'(ax) >> 2) + int'(ay) + k*3), 12'(k*291 + int'(ax)*7 + int'(ay)*13)};
    return {fix_mask[k], fix_rgb[k]};
  endfunction

  // Unselected layers return junk so a compositor that ignores hit gets caught
  function automatic logic [N*16-1:0] rom_bus(input logic [N-1:0] rd, input logic [N*CW-1:0] ax, input logic [N*CW-1:0] ay);
    logic [N*16-1:0] r;
    logic [15:0] w;
    r = '0;
    for (int k = 0; k < int'(N); k++) begin
      w = rd[k] ? rom_word(k, ax[k*CW +: CW], ay[k*CW +: CW]) : 16'($urandom);
      r[k*12 +: 12]    = w[11:0];
      r[N*12 + k*4 +: 4] = w[15:12];
    end
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) pipe1[0] <= rom_bus(rd1, ax1, ay1);
  always @(posedge clk) begin
    pipe3[2] <= pipe3[1];
    pipe3[1] <= pipe3[0];
    pipe3[0] <= rom_bus(rd3, ax3, ay3);
  end

  function automatic logic [3:0] fch(input logic [3:0] v, input int lvl);
    return (int'(v) > lvl) ? 4'(int'(v) - lvl) : 4'd0;
  endfunction

  // Reference: scan from the top layer down, first opaque hit wins
  function automatic logic [11:0] model_pix(input int x, input int y, input int lvl);
    logic [11:0] c;
    logic [15:0] w;
    int lx, ly;
    c = bg;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      lx = (x - lay_x[k]) & 1023;
      ly = (y - lay_y[k]) & 1023;
      if (en[k] && lx < lay_w[k] && ly < lay_h[k]) begin
        w = rom_word(k, CW'(lx), CW'(ly));
        if (w[15:12] > 4'd5) begin
          c = w[11:0];
          break;
        end
      end
    end
    return {fch(c[11:8], lvl), fch(c[7:4], lvl), fch(c[3:0], lvl)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [11:0] e);
    q1.push_back('{rgb: e, due: cyc + 3});
    q3.push_back('{rgb: e, due: cyc + 5});
  endtask

  task automatic drive_pix(input int x, input int y, input int lvl);
    valid = 1'b1;
    x_rd  = CW'(x);
    y_rd  = CW'(y);
    push_exp(model_pix(x, y, lvl));
  endtask

  // Every cycle: o_valid exactly when a pixel is due, with the expected colour
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      if (q1.size() > 0 && q1[0].due == cyc) begin
        check("valid_l1", 32'(vld1), 1);
        check("rgb_l1", 32'(rgb1), 32'(q1[0].rgb));
        void'(q1.pop_front());
      end else check("idle_valid_l1", 32'(vld1), 0);
      if (q3.size() > 0 && q3[0].due == cyc) begin
        check("valid_l3", 32'(vld3), 1);
        check("rgb_l3", 32'(rgb3), 32'(q3[0].rgb));
        void'(q3.pop_front());
      end else check("idle_valid_l3", 32'(vld3), 0);
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_rgb1"}, 32'(rgb1), 0);   check({tag, "_rgb3"}, 32'(rgb3), 0);
    check({tag, "_vld1"}, 32'(vld1), 0);   check({tag, "_vld3"}, 32'(vld3), 0);
    check({tag, "_rd1"}, 32'(rd1), 0);     check({tag, "_rd3"}, 32'(rd3), 0);
    check({tag, "_ax1"}, 32'(ax1), 0);     check({tag, "_ay3"}, 32'(ay3), 0);
    check({tag, "_lvl1"}, 32'(lvl1), 0);   check({tag, "_lvl3"}, 32'(lvl3), 0);
    check({tag, "_busy1"}, 32'(busy1), 0); check({tag, "_busy3"}, 32'(busy3), 0);
  endtask

  task automatic frame(input logic req, input int exp_lvl, input logic exp_busy, input string tag);
    @(negedge clk);
    fade_req    = req;
    frame_start = 1'b1;
    drive_pix($urandom_range(0, 1023), $urandom_range(0, 1023), exp_lvl);
    @(negedge clk);
    frame_start = 1'b0;
    valid       = 1'b0;
    check({tag, "_lvl1"}, 32'(lvl1), 32'(exp_lvl));
    check({tag, "_lvl3"}, 32'(lvl3), 32'(exp_lvl));
    check({tag, "_busy1"}, 32'(busy1), 32'(exp_busy));
    check({tag, "_busy3"}, 32'(busy3), 32'(exp_busy));
    repeat (5) @(negedge clk);
  endtask

  task automatic cfg_random();
    for (int k = 0; k < int'(N); k++) begin
      lay_x[k] = $urandom_range(0, 700);
      lay_y[k] = $urandom_range(0, 500);
      lay_w[k] = $urandom_range(0, 300);
      lay_h[k] = $urandom_range(0, 300);
    end
    en     = N'($urandom);
    bg     = 12'($urandom);
    pat_en = 1'b1;
  endtask

  task automatic stream(input int n, input int lvl);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      drive_pix($urandom_range(0, 1023), $urandom_range(0, 1023), lvl);
    end
    @(negedge clk);
    valid = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; valid = 1'b0; frame_start = 1'b0; fade_req = 1'b0;
    x_rd = '0; y_rd = '0; en = '0; bg = '0; pat_en = 1'b0; chk_en = 1'b0;
    lay_x = '{100, 0, 120, 100}; lay_y = '{50, 0, 60, 50};
    lay_w = '{50, 0, 30, 50};    lay_h = '{100, 1023, 30, 0};
    fix_rgb  = '{12'h0F0, 12'hAAA, 12'hF00, 12'h555};
    fix_mask = '{4'hF, 4'hF, 4'h9, 4'hF};

    tbl[0]  = '{100, 50, 4'b0001, 12'h0F0, 4'hF, 12'hF00, 4'h9, 12'h123, 12'h0F0, 4'b0001, 10'd0, 10'd0};
    tbl[1]  = '{99, 50, 4'b0001, 12'h0F0, 4'hF, 12'hF00, 4'h9, 12'h123, 12'h123, 4'b0000, 10'd1023, 10'd0};
    tbl[2]  = '{149, 149, 4'b0001, 12'h0F0, 4'hF, 12'hF00, 4'h9, 12'h123, 12'h0F0, 4'b0001, 10'd49, 10'd99};
    tbl[3]  = '{150, 50, 4'b0001, 12'h0F0, 4'hF, 12'hF00, 4'h9, 12'h123, 12'h123, 4'b0000, 10'd50, 10'd0};
    tbl[4]  = '{100, 150, 4'b0001, 12'h0F0, 4'hF, 12'hF00, 4'h9, 12'h123, 12'h123, 4'b0000, 10'd0, 10'd100};
    tbl[5]  = '{100, 49, 4'b0001, 12'h0F0, 4'hF, 12'hF00, 4'h9, 12'h123, 12'h123, 4'b0000, 10'd0, 10'd1023};
    tbl[6]  = '{125, 70, 4'b0101, 12'h00F, 4'h9, 12'hF00, 4'h9, 12'h123, 12'hF00, 4'b0101, 10'd25, 10'd20};
    tbl[7]  = '{125, 70, 4'b0101, 12'h00F, 4'h9, 12'hF00, 4'h5, 12'h123, 12'h00F, 4'b0101, 10'd25, 10'd20};
    tbl[8]  = '{125, 70, 4'b0101, 12'h00F, 4'h9, 12'hF00, 4'h6, 12'h123, 12'hF00, 4'b0101, 10'd25, 10'd20};
    tbl[9]  = '{125, 70, 4'b0101, 12'h00F, 4'h5, 12'hF00, 4'h5, 12'h123, 12'h123, 4'b0101, 10'd25, 10'd20};
    tbl[10] = '{125, 70, 4'b1111, 12'h00F, 4'h9, 12'hF00, 4'h0, 12'h123, 12'h00F, 4'b0101, 10'd25, 10'd20};
    tbl[11] = '{125, 70, 4'b1111, 12'h00F, 4'h9, 12'hF00, 4'h9, 12'h123, 12'hF00, 4'b0101, 10'd25, 10'd20};
    tbl[12] = '{125, 70, 4'b0100, 12'h00F, 4'h9, 12'hF00, 4'h9, 12'h123, 12'hF00, 4'b0100, 10'd25, 10'd20};
    tbl[13] = '{150, 60, 4'b0101, 12'h00F, 4'h9, 12'hF00, 4'h9, 12'h456, 12'h456, 4'b0000, 10'd50, 10'd10};
    tbl[14] = '{149, 89, 4'b0101, 12'h00F, 4'h9, 12'hF00, 4'h9, 12'h456, 12'hF00, 4'b0101, 10'd49, 10'd39};

    #12;
    check_zero("reset");
    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 15; i++) begin
      fix_rgb[0] = tbl[i].rgb0; fix_mask[0] = tbl[i].m0;
      fix_rgb[2] = tbl[i].rgb2; fix_mask[2] = tbl[i].m2;
      en = tbl[i].en;
      bg = tbl[i].bg;
      @(negedge clk);
      valid = 1'b1;
      x_rd  = CW'(tbl[i].px);
      y_rd  = CW'(tbl[i].py);
      push_exp(tbl[i].exp_rgb);
      @(negedge clk);
      valid = 1'b0;
      check($sformatf("tbl%0d_rd1", i), 32'(rd1), 32'(tbl[i].exp_rd));
      check($sformatf("tbl%0d_rd3", i), 32'(rd3), 32'(tbl[i].exp_rd));
      check($sformatf("tbl%0d_ax0", i), 32'(ax1[CW-1:0]), 32'(tbl[i].exp_ax0));
      check($sformatf("tbl%0d_ay0", i), 32'(ay3[CW-1:0]), 32'(tbl[i].exp_ay0));
      @(negedge clk);
      check($sformatf("tbl%0d_rd_idle", i), 32'(rd1), 0);
      repeat (6) @(negedge clk);
    end

    for (int r = 0; r < 2; r++) begin
      cfg_random();
      stream(640, 0);
    end

    en = '0; bg = 12'hFFF; pat_en = 1'b0;
    frame(1'b1, 0, 1'b1, "entry");
    for (int i = 1; i <= 60; i++) frame(1'b1, i / 4, (i < 60), "fade_out");
    frame(1'b1, 15, 1'b0, "dark_hold");
    frame(1'b0, 15, 1'b1, "dark_exit");
    for (int j = 1; j <= 60; j++) frame(1'b0, 15 - j / 4, (j < 60), "fade_in");
    frame(1'b0, 0, 1'b0, "idle_hold");

    frame(1'b1, 0, 1'b1, "entry2");
    for (int i = 1; i <= 28; i++) frame(1'b1, i / 4, 1'b1, "out2");
    frame(1'b0, 7, 1'b1, "drop");
    for (int j = 1; j <= 6; j++) frame(1'b0, 7 - j / 4, 1'b1, "in2");
    cfg_random();
    stream(100, 6);
    frame(1'b1, 6, 1'b1, "reraise");
    for (int i = 1; i <= 4; i++) frame(1'b1, (i == 4) ? 7 : 6, 1'b1, "out3");

    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      drive_pix($urandom_range(0, 1023), $urandom_range(0, 1023), 7);
      if (i == 15) begin
        #2;
        rst_n = 1'b0;
        valid = 1'b0;
        q1.delete();
        q3.delete();
        #1;
        check_zero("midrst");
        break;
      end
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    drive_pix(125, 70, 0);
    @(negedge clk);
    valid = 1'b0;
    repeat (8) @(negedge clk);
    check("post_rst_lvl", 32'(lvl1), 0);
    check("post_rst_busy", 32'(busy3), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
